// File: rtl/debug_monitor_mux.sv
// debug_monitor_mux: debounced channel selector for the debug header/LEDs
// with LIVE, HOLD, SCAN and PEAK display modes.
module debug_monitor_mux #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int LED_W     = 8,
  parameter int DEB_CYC   = 38000,
  parameter int SCAN_CYC  = 38000000,
  parameter int STALE_CYC = 3800000,
  parameter logic [DATA_W-1:0] DBG_RST = 16'hAAAA,
  parameter logic [LED_W-1:0]  LED_RST = 8'hAA,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sys_clk,
  input  logic                     resetn,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     sel_btn_n,
  input  logic [1:0]               mode,
  output logic [DATA_W-1:0]        debug_out,
  output logic [LED_W-1:0]         led_out,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     stale
);

  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int SCAN_W  = $clog2(SCAN_CYC + 1);
  localparam int STALE_W = $clog2(STALE_CYC + 1);

  typedef enum logic [1:0] {
    M_LIVE = 2'b00,
    M_HOLD = 2'b01,
    M_SCAN = 2'b10,
    M_PEAK = 2'b11
  } mode_e;

  logic               btn_s1;
  logic               btn_s2;
  logic               btn_deb;
  logic [DEB_W-1:0]   deb_cnt;
  logic               deb_hit;
  logic               press;

  mode_e              mode_r;
  logic               mode_chg;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [STALE_W-1:0] stale_cnt;
  logic [DATA_W-1:0]  peak;
  logic               scan_hit;
  logic               step;

  logic [DATA_W-1:0]  words [NUM_CH];
  logic [DATA_W-1:0]  sel_word;
  logic               sel_valid;
  logic [DATA_W-1:0]  dbg_nxt;

  function automatic logic [DATA_W:0] mag(
    input logic [DATA_W-1:0] w
  );
    logic [DATA_W:0] x;
    x = {w[DATA_W-1], w};
    return w[DATA_W-1] ? -x : x;
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_words
    assign words[k] = ch_data[k*DATA_W +: DATA_W];
  end

  assign sel_word  = words[cur_ch];
  assign sel_valid = ch_valid[cur_ch];

  // a new level is accepted only after DEB_CYC identical samples
  assign deb_hit = (btn_s2 != btn_deb) &&
                   (deb_cnt == DEB_W'(DEB_CYC - 1));
  assign press   = deb_hit && btn_deb;

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_deb <= 1'b1;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= sel_btn_n;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_hit) begin
        btn_deb <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign mode_chg = (mode != mode_r);
  assign scan_hit = (mode_r == M_SCAN) &&
                    (scan_cnt == SCAN_W'(SCAN_CYC - 1));
  assign step     = scan_hit ||
                    (press && (mode_r != M_SCAN));

  // the cycle a mode switch is registered leaves the display untouched
  always_comb begin
    dbg_nxt = debug_out;
    if (!mode_chg) begin
      unique case (mode_r)
        M_LIVE, M_SCAN: dbg_nxt = sel_word;
        M_HOLD: if (sel_valid) dbg_nxt = sel_word;
        M_PEAK: dbg_nxt = peak;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      mode_r    <= M_LIVE;
      cur_ch    <= '0;
      scan_cnt  <= '0;
      stale_cnt <= '0;
      peak      <= '0;
      debug_out <= DBG_RST;
      led_out   <= LED_RST;
    end else begin
      mode_r    <= mode_e'(mode);
      debug_out <= dbg_nxt;
      led_out   <= ~dbg_nxt[LED_W-1:0];
      if (step) begin
        cur_ch <= (cur_ch == CH_W'(NUM_CH - 1)) ?
                  '0 : cur_ch + 1'b1;
      end
      if (mode_chg || mode_r != M_SCAN || scan_hit) begin
        scan_cnt <= '0;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (mode_chg || mode_r != M_HOLD ||
          sel_valid || step) begin
        stale_cnt <= '0;
      end else if (stale_cnt != STALE_W'(STALE_CYC)) begin
        stale_cnt <= stale_cnt + 1'b1;
      end
      if (mode_chg || step) begin
        peak <= '0;
      end else if (mode_r == M_PEAK &&
                   mag(sel_word) > mag(peak)) begin
        peak <= sel_word;
      end
    end
  end

  assign stale = (mode_r == M_HOLD) &&
                 (stale_cnt == STALE_W'(STALE_CYC));

endmodule

// File: tb/tb_debug_monitor_mux.sv
// tb_debug_monitor_mux: directed stimulus, cycle model of the display
// rules, and literal checks for the debug monitor mux.
module tb_debug_monitor_mux;

  localparam int NCH   = 4;
  localparam int DW    = 16;
  localparam int LW    = 8;
  localparam int DEB   = 8;
  localparam int SCAN  = 10;
  localparam int STALE = 20;

  logic          sys_clk = 1'b0;
  logic          resetn;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0] ch_valid;
  logic          sel_btn_n;
  logic [1:0]    mode;
  logic [DW-1:0] debug_out;
  logic [LW-1:0] led_out;
  logic [1:0]    cur_ch;
  logic          stale;

  int n_cmp = 0;
  int n_bad = 0;

  debug_monitor_mux #(
    .NUM_CH(NCH), .DATA_W(DW), .LED_W(LW),
    .DEB_CYC(DEB), .SCAN_CYC(SCAN), .STALE_CYC(STALE),
    .DBG_RST(16'hAAAA), .LED_RST(8'hAA)
  ) dut (
    .sys_clk(sys_clk), .resetn(resetn),
    .ch_data(ch_data), .ch_valid(ch_valid),
    .sel_btn_n(sel_btn_n), .mode(mode),
    .debug_out(debug_out), .led_out(led_out),
    .cur_ch(cur_ch), .stale(stale)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_init = 0;
  bit            hist[$];
  bit            m_deb;
  int            m_mode, m_ch, m_scan, m_stc;
  logic [DW-1:0] m_dbg, m_peak;
  logic [LW-1:0] m_led;

  function automatic int absv(input logic [DW-1:0] w);
    int v;
    v = int'($signed(w));
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge sys_clk) begin
    bit flip, press, chg, step, vsel;
    logic [DW-1:0] w;
    if (!resetn) begin
      m_init = 1;
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b1);
      m_deb = 1; m_mode = 0; m_ch = 0;
      m_scan = 0; m_stc = 0; m_peak = '0;
      m_dbg = 16'hAAAA; m_led = 8'hAA;
    end else if (m_init) begin
      hist.push_back(sel_btn_n);
      hist.delete(0);
      // the button level seen DEB times in a row, two samples late
      flip = 1;
      for (int i = 0; i < DEB; i++)
        if (hist[i] == m_deb) flip = 0;
      press = flip && m_deb;
      chg = (int'(mode) != m_mode);
      w = ch_data[m_ch*DW +: DW];
      vsel = ch_valid[m_ch];
      step = (m_mode != 2 && press) ||
             (m_mode == 2 && m_scan == SCAN - 1);
      if (!chg) begin
        if (m_mode == 0 || m_mode == 2) m_dbg = w;
        else if (m_mode == 1 && vsel) m_dbg = w;
        else if (m_mode == 3) m_dbg = m_peak;
      end
      if (chg || step) m_peak = '0;
      else if (m_mode == 3 && absv(w) > absv(m_peak))
        m_peak = w;
      if (chg || m_mode != 1 || vsel || step) m_stc = 0;
      else if (m_stc < STALE) m_stc++;
      if (chg || m_mode != 2 || m_scan == SCAN - 1)
        m_scan = 0;
      else m_scan++;
      if (step) m_ch = (m_ch + 1) % NCH;
      if (flip) m_deb = !m_deb;
      m_mode = int'(mode);
      m_led = ~m_dbg[LW-1:0];
    end
  end

  always @(negedge sys_clk) begin
    if (m_init) begin
      chk("debug_out", 32'(debug_out), 32'(m_dbg));
      chk("led_out", 32'(led_out), 32'(m_led));
      chk("cur_ch", 32'(cur_ch), 32'(m_ch));
      chk("stale", 32'(stale),
          32'(m_mode == 1 && m_stc == STALE));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    ch_data[k*DW +: DW] = v;
  endtask

  task automatic press_btn();
    sel_btn_n = 1'b0;
    tick(DEB + 6);
    sel_btn_n = 1'b1;
    tick(DEB + 6);
  endtask

  task automatic wait_ch(input int tgt, output int k);
    k = 0;
    while (int'(cur_ch) != tgt && k < 40) begin
      tick(1);
      k++;
    end
    if (k >= 40)
      $display("FAIL wait_ch: timeout, cur_ch %0d expected %0d",
               cur_ch, tgt);
  endtask

  initial begin
    int k;
    int seq_pre[4];
    int seq_post[4];
    seq_pre  = '{2, 3, 0, 1};
    seq_post = '{3, 0, 1, 2};
    resetn = 1'b0; sel_btn_n = 1'b1; mode = 2'b00;
    ch_valid = '0;
    set_ch(0, 16'h0011); set_ch(1, 16'h1111);
    set_ch(2, 16'h2222); set_ch(3, 16'h3333);

    // T1 reset
    tick(3);
    chk("rst_dbg", 32'(debug_out), 32'hAAAA);
    chk("rst_led", 32'(led_out), 32'hAA);
    chk("rst_ch", 32'(cur_ch), 0);
    chk("rst_stale", 32'(stale), 0);
    resetn = 1'b1;
    tick(2);
    chk("live_dbg", 32'(debug_out), 32'h0011);
    chk("live_led", 32'(led_out), 32'hEE);

    // T2 debounce
    sel_btn_n = 1'b0; tick(5);
    sel_btn_n = 1'b1; tick(5);
    chk("glitch_ch", 32'(cur_ch), 0);
    sel_btn_n = 1'b0;
    wait_ch(1, k);
    chk("deb_latency", 32'(k), 32'(DEB + 2));
    tick(20);
    chk("held_ch", 32'(cur_ch), 1);
    sel_btn_n = 1'b1; tick(20);
    chk("release_ch", 32'(cur_ch), 1);
    repeat (4) press_btn();
    chk("wrap_ch", 32'(cur_ch), 1);

    // T3 HOLD
    mode = 2'b01; tick(2);
    set_ch(1, 16'h1234); ch_valid = 4'b0010; tick(1);
    ch_valid = '0; set_ch(1, 16'h5678); tick(3);
    chk("hold_dbg", 32'(debug_out), 32'h1234);
    chk("hold_led", 32'(led_out), 32'hCB);
    chk("hold_fresh", 32'(stale), 0);
    tick(STALE);
    chk("stale_set", 32'(stale), 1);
    ch_valid = 4'b0001; tick(1); ch_valid = '0;
    chk("stale_other", 32'(stale), 1);
    ch_valid = 4'b0010; tick(1); ch_valid = '0;
    chk("stale_clr", 32'(stale), 0);
    chk("hold_new", 32'(debug_out), 32'h5678);
    press_btn();
    chk("hold_step_ch", 32'(cur_ch), 2);
    chk("hold_keep", 32'(debug_out), 32'h5678);
    ch_valid = 4'b0100; tick(1); ch_valid = '0;
    chk("hold_ch2", 32'(debug_out), 32'h2222);

    // T4 SCAN, button held in window 1 must be ignored
    mode = 2'b10; tick(1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) sel_btn_n = 1'b0;
      if (i == 2) sel_btn_n = 1'b1;
      tick(SCAN - 1);
      chk("scan_pre", 32'(cur_ch), 32'(seq_pre[i]));
      tick(1);
      chk("scan_step", 32'(cur_ch), 32'(seq_post[i]));
    end

    // T5 PEAK
    mode = 2'b11; set_ch(0, 16'h0000); tick(2);
    press_btn(); press_btn();
    chk("peak_ch0", 32'(cur_ch), 0);
    set_ch(0, 16'h0005); tick(1);
    set_ch(0, 16'hFFF9); tick(1);
    chk("peak_5", 32'(debug_out), 32'h0005);
    set_ch(0, 16'h0006); tick(1);
    chk("peak_m7", 32'(debug_out), 32'hFFF9);
    set_ch(0, 16'h8000); tick(1);
    chk("peak_keep", 32'(debug_out), 32'hFFF9);
    set_ch(0, 16'h7FFF); tick(1);
    chk("peak_min", 32'(debug_out), 32'h8000);
    tick(2);
    chk("peak_min2", 32'(debug_out), 32'h8000);
    sel_btn_n = 1'b0;
    wait_ch(1, k);
    tick(2);
    chk("peak_newch", 32'(debug_out), 32'h5678);
    sel_btn_n = 1'b1; tick(DEB + 6);

    // T6 reset mid-press and mid-scan
    mode = 2'b00; tick(2);
    sel_btn_n = 1'b0;
    wait_ch(2, k);
    tick(3);
    resetn = 1'b0; tick(2);
    chk("mid_rst_ch", 32'(cur_ch), 0);
    chk("mid_rst_dbg", 32'(debug_out), 32'hAAAA);
    resetn = 1'b1; tick(3);
    sel_btn_n = 1'b1; tick(3 * DEB);
    chk("post_rst_ch", 32'(cur_ch), 0);
    mode = 2'b10; tick(15);
    chk("scan_mid", 32'(cur_ch), 1);
    resetn = 1'b0; tick(1);
    chk("scan_rst", 32'(cur_ch), 0);
    resetn = 1'b1; tick(SCAN);
    chk("scan_re0", 32'(cur_ch), 0);
    tick(1);
    chk("scan_re1", 32'(cur_ch), 1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
